regfile_mp_scoreboard: RTL and testbench
========================================

Name: regfile_mp_scoreboard

Overview:
- Parametrised multi-port integer register file with a built-in busy scoreboard, for the pipelined core.
- Provides NRD combinational read ports and NWR write ports, with optional same-cycle write-to-read bypass.
- Keeps a per-register busy bit, set at issue and cleared at writeback, so the decode stage can detect RAW/WAW hazards.
- Includes a debug read port for the simulation environment.

Parameters:
XLEN, 64, data width of each register
NREG, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = reads see only committed state
AW, $clog2(NREG), address width (derived, not overridden)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  busy bit of each read address (hazard indication)
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
wr_resp  out  NWR  registered write acknowledge, one per port
iss_en  in  1  issue request: mark iss_addr busy
iss_addr  in  AW  destination of the instruction being issued
iss_ok  out  1  issue accepted this cycle
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data (committed state, never bypassed)

Behaviour:
- Reset (async, rst_n=0):
  - All registers := 0; all busy bits := 0; wr_resp := 0.
  - Combinational outputs follow the cleared state.
  - A reset asserted mid-write discards that write.
- x0 is hardwired:
  - Register 0 always reads 0 and its busy bit is always 0.
  - Writes to address 0 are ignored, but wr_resp is still asserted for them.
- Writes:
  - On a clk edge with wr_en[i]=1, rf[wr_addr[i]] := wr_data[i].
  - Visible on rd_data from the next cycle (or the same cycle when BYPASS=1).
- Write conflict: several ports writing the same address in one cycle -> the highest port index wins, for both storage and bypass.
- wr_resp[i] := wr_en[i], registered. Exactly one-cycle latency, one pulse per write cycle.
- Reads: rd_data[i] is combinational.
  - addr 0 -> 0.
  - Else, if BYPASS=1 and some enabled write targets the same address -> that write's data (highest index wins).
  - Else -> rf[addr].
- rd_busy[i] is combinational: busy[addr], forced to 0 when BYPASS=1 and a same-cycle write targets addr. It is always 0 for addr 0.
- Issue:
  - iss_ok = iss_en & ~busy_eff[iss_addr], where busy_eff is busy with same-cycle write clears applied when BYPASS=1. This gives a WAW stall.
  - iss_addr=0 -> iss_ok = iss_en, and no busy bit is set.
- Busy update at the clk edge:
  - Clear busy[wr_addr[i]] for every enabled write port.
  - Then set busy[iss_addr] if iss_ok and iss_addr != 0.
  - When a set and a clear hit the same address in one cycle, the set wins (the new producer owns it).
- A write to a non-busy register is legal. It updates data and leaves busy at 0.
- No internal state machine beyond the per-register busy table. Throughput is one issue and NWR writes per cycle.

Decomposition:
- Shared package (core_rf_pkg):
  - XLEN, NREG, AW constants.
  - typedef reg_addr_t (logic [AW-1:0]) and xlen_t (logic [XLEN-1:0]).
  - REG_ZERO constant.
- Sub-module regfile_busy_table holds the NREG busy flops:
  - Inputs: clear vector from the write ports, iss_ok/iss_addr set, bypass flag.
  - Outputs: the busy_eff vector.
  - Keeps the set-over-clear priority in one place.
- The data array, bypass muxes and wr_resp stay in the top module.

Test Plan:
- Reset then reads: rst_n low 3 cycles, release; read ports at addr 5 and 31 -> rd_data=0, rd_busy=0, wr_resp=0, dbg_data=0.
- Write/readback with bypass: wr_en[0]=1, addr 7, data 64'hDEAD_BEEF_0000_0001, rd_addr0=7 in the same cycle -> rd_data0=that value (BYPASS=1) and wr_resp[0]=1 next cycle. With BYPASS=0 the value appears only from the next cycle; dbg_data=value after the edge.
- x0 protection: write 64'hFFFF to addr 0 -> rd_data=0, dbg_data=0, wr_resp[0]=1 next cycle; iss_en with iss_addr=0 -> iss_ok=1 and rd_busy for addr 0 stays 0.
- Port conflict: ports 0 and 1 both write addr 3 with 0x11 and 0x22 -> bypass and stored value both 0x22.
- Scoreboard:
  - Issue to addr 9 -> next cycle rd_busy=1 and a second issue to 9 gives iss_ok=0.
  - Write port 1 to 9 in that same cycle -> with BYPASS=1 iss_ok=1 and busy stays 1 (set wins); with BYPASS=0 iss_ok=0.
- Async reset mid-operation: assert rst_n=0 between edges while registers 4 and 9 are busy and hold data -> busy and data clear immediately without waiting for clk, and no wr_resp pulse follows.

Source files
------------

// File: rtl/core_rf_pkg.sv
// Shared definitions for the integer register file and its busy scoreboard.
// Provides the default architectural sizes, address/data typedefs and the
// hardwired-zero register index.
package core_rf_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

    // x0 reads as zero, is never written and is never marked busy.
    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_busy_table.sv
// Per-register busy scoreboard.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr_i         one bit per register, set when a write port targets it
//   set_en_i      issue accepted this cycle
//   set_addr_i    destination register of the accepted issue
//   busy_eff_o    busy vector as seen by decode this cycle
module regfile_busy_table
    import core_rf_pkg::*;
#(
    parameter int NREG   = core_rf_pkg::NREG,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREG-1:0] clr_i,
    input  logic            set_en_i,
    input  logic [AW-1:0]   set_addr_i,
    output logic [NREG-1:0] busy_eff_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears are applied first and the set last, so a new producer issued in
    // the same cycle as the old producer's writeback keeps the register busy.
    // NOTE: every variable written in always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        busy_d = busy_q & ~clr_i;
        if (set_en_i && set_addr_i != AW'(REG_ZERO)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // With bypass, a register being written back this cycle already looks free.
    always_comb begin
        busy_eff_o    = BYPASS ? (busy_q & ~clr_i) : busy_q;
        busy_eff_o[0] = 1'b0;
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with busy scoreboard.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_addr/rd_data     NRD combinational read ports (optionally bypassed)
//   rd_busy             busy bit of each read address
//   wr_en/addr/data     NWR write ports; highest port index wins a conflict
//   wr_resp             registered write acknowledge, one per port
//   iss_en/iss_addr     issue request marking a destination busy
//   iss_ok              issue accepted this cycle (WAW stall when low)
//   dbg_addr/dbg_data   committed-state debug read, never bypassed
module regfile_mp_scoreboard
    import core_rf_pkg::*;
#(
    parameter int XLEN   = core_rf_pkg::XLEN,
    parameter int NREG   = core_rf_pkg::NREG,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [NWR-1:0]      wr_resp,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ok,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NWR-1:0]  wr_resp_q;
    logic [NREG-1:0] wr_clr;
    logic [NREG-1:0] busy_eff;

    // NOTE: the array is reset explicitly because a reset must clear all
    // architectural state; this keeps it in flops rather than a RAM macro.
    // NOTE: non-blocking assignments in a loop: the last scheduled update to
    // an entry takes effect, so the highest write port wins a conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= '0;
            end
            wr_resp_q <= '0;
        end else begin
            wr_resp_q <= wr_en;
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_addr[i*AW +: AW] != AW'(REG_ZERO)) begin
                    rf_q[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    assign wr_resp = wr_resp_q;

    always_comb begin
        wr_clr = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                wr_clr[wr_addr[i*AW +: AW]] = 1'b1;
            end
        end
    end

    regfile_busy_table #(
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_busy (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (wr_clr),
        .set_en_i   (iss_ok),
        .set_addr_i (iss_addr),
        .busy_eff_o (busy_eff)
    );

    // busy_eff[0] is tied low, so an issue to x0 is always accepted.
    assign iss_ok = iss_en & ~busy_eff[iss_addr];

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            data = rf_q[addr];
            if (BYPASS) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == addr) begin
                        data = wr_data[j*XLEN +: XLEN];
                    end
                end
            end
            if (addr == AW'(REG_ZERO)) begin
                data = '0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = data;
        assign rd_busy[p]              = busy_eff[addr];
    end

    // rf_q[0] is never written, so the debug port needs no zero override.
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: one BYPASS=1 and one BYPASS=0 instance
// share all inputs and are compared against a behavioural model.
module tb_regfile_mp_scoreboard;

    localparam int XL  = 64;
    localparam int NR  = 32;
    localparam int AWT = 5;
    localparam int NRP = 2;
    localparam int NWP = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NRP*AWT-1:0] rd_addr = '0;
    logic [NWP-1:0]     wr_en = '0;
    logic [NWP*AWT-1:0] wr_addr = '0;
    logic [NWP*XL-1:0]  wr_data = '0;
    logic               iss_en = 1'b0;
    logic [AWT-1:0]     iss_addr = '0;
    logic [AWT-1:0]     dbg_addr = '0;

    // Index 1 = bypass instance, index 0 = no-bypass instance.
    logic [NRP*XL-1:0]  rdd  [2];
    logic [NRP-1:0]     rdb  [2];
    logic [NWP-1:0]     resp [2];
    logic               isok [2];
    logic [XL-1:0]      dbgd [2];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model.
    logic [XL-1:0]  m_rf   [NR];
    bit             m_busy [2][NR];
    logic [NWP-1:0] m_resp;

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(.XLEN(XL), .NREG(NR), .NRD(NRP), .NWR(NWP), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_busy(rdb[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_resp(resp[1]),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(isok[1]),
        .dbg_addr(dbg_addr), .dbg_data(dbgd[1])
    );

    regfile_mp_scoreboard #(.XLEN(XL), .NREG(NR), .NRD(NRP), .NWR(NWP), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_busy(rdb[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_resp(resp[0]),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(isok[0]),
        .dbg_addr(dbg_addr), .dbg_data(dbgd[0])
    );

    // ---------------- model ----------------
    function automatic bit same_cycle_write(input int a, output logic [XL-1:0] d);
        bit found = 1'b0;
        d = '0;
        for (int j = 0; j < NWP; j++) begin
            if (wr_en[j] && int'(wr_addr[j*AWT +: AWT]) == a) begin
                found = 1'b1;
                d = wr_data[j*XL +: XL];
            end
        end
        return found;
    endfunction

    function automatic logic [XL-1:0] exp_rd(input int byp, input int a);
        logic [XL-1:0] d;
        if (a == 0) return '0;
        if (byp == 1 && same_cycle_write(a, d)) return d;
        return m_rf[a];
    endfunction

    function automatic bit exp_busy(input int byp, input int a);
        logic [XL-1:0] d;
        if (a == 0) return 1'b0;
        if (byp == 1 && same_cycle_write(a, d)) return 1'b0;
        return m_busy[byp][a];
    endfunction

    function automatic bit exp_iss(input int byp);
        return iss_en && !exp_busy(byp, int'(iss_addr));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_rf[r] = '0;
            m_busy[0][r] = 1'b0;
            m_busy[1][r] = 1'b0;
        end
        m_resp = '0;
    endtask

    task automatic model_edge();
        bit ok [2];
        for (int b = 0; b < 2; b++) ok[b] = exp_iss(b);
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < NWP; j++)
                if (wr_en[j]) m_busy[b][int'(wr_addr[j*AWT +: AWT])] = 1'b0;
            if (ok[b] && iss_addr != 0) m_busy[b][int'(iss_addr)] = 1'b1;
        end
        for (int j = 0; j < NWP; j++)
            if (wr_en[j] && wr_addr[j*AWT +: AWT] != 0)
                m_rf[int'(wr_addr[j*AWT +: AWT])] = wr_data[j*XL +: XL];
        m_resp = wr_en;
    endtask

    // Advance one clock edge (model follows) and return at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        @(negedge clk);
    endtask

    task automatic set_wr(input int p, input bit en, input int a, input logic [XL-1:0] d);
        wr_en[p] = en;
        wr_addr[p*AWT +: AWT] = AWT'(a);
        wr_data[p*XL +: XL] = d;
    endtask

    task automatic idle();
        wr_en = '0;
        iss_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_addr = {AWT'(31), AWT'(5)};
        dbg_addr = AWT'(5);
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (rdd[b] !== '0 || rdb[b] !== '0 || resp[b] !== '0 || dbgd[b] !== '0) begin
                n_err++;
                $display("FAIL reset b%0d: rd_data=%h rd_busy=%b wr_resp=%b dbg=%h, want all 0",
                         b, rdd[b], rdb[b], resp[b], dbgd[b]);
            end
        end
    endtask

    task automatic test_write_bypass();
        logic [XL-1:0] v = 64'hDEAD_BEEF_0000_0001;
        set_wr(0, 1'b1, 7, v);
        rd_addr[0 +: AWT] = AWT'(7);
        dbg_addr = AWT'(7);
        #1;
        n_vec++;
        if (rdd[1][0 +: XL] !== v) begin
            n_err++; $display("FAIL wr_bypass_same: got %h want %h", rdd[1][0 +: XL], v);
        end
        n_vec++;
        if (rdd[0][0 +: XL] !== '0) begin
            n_err++; $display("FAIL wr_nobypass_same: got %h want 0", rdd[0][0 +: XL]);
        end
        cycle();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (resp[b] !== 2'b01 || rdd[b][0 +: XL] !== v || dbgd[b] !== v) begin
                n_err++;
                $display("FAIL wr_after_edge b%0d: resp=%b rd=%h dbg=%h want 01 %h %h",
                         b, resp[b], rdd[b][0 +: XL], dbgd[b], v, v);
            end
        end
    endtask

    task automatic test_x0();
        set_wr(0, 1'b1, 0, 64'hFFFF);
        rd_addr = '0;
        dbg_addr = '0;
        iss_en = 1'b1;
        iss_addr = '0;
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (rdd[b] !== '0 || isok[b] !== 1'b1 || rdb[b] !== '0) begin
                n_err++;
                $display("FAIL x0_same b%0d: rd=%h iss_ok=%b busy=%b want 0 1 00",
                         b, rdd[b], isok[b], rdb[b]);
            end
        end
        cycle();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (resp[b] !== 2'b01 || dbgd[b] !== '0 || rdd[b] !== '0 || rdb[b] !== '0) begin
                n_err++;
                $display("FAIL x0_after b%0d: resp=%b dbg=%h rd=%h busy=%b want 01 0 0 00",
                         b, resp[b], dbgd[b], rdd[b], rdb[b]);
            end
        end
    endtask

    task automatic test_conflict();
        set_wr(0, 1'b1, 3, 64'h11);
        set_wr(1, 1'b1, 3, 64'h22);
        rd_addr = {AWT'(3), AWT'(3)};
        #1;
        n_vec++;
        if (rdd[1][0 +: XL] !== 64'h22 || rdd[1][XL +: XL] !== 64'h22) begin
            n_err++; $display("FAIL conflict_bypass: got %h want 22 on both ports", rdd[1]);
        end
        cycle();
        idle();
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (rdd[b][0 +: XL] !== 64'h22) begin
                n_err++; $display("FAIL conflict_stored b%0d: got %h want 22", b, rdd[b][0 +: XL]);
            end
        end
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1;
        iss_addr = AWT'(9);
        rd_addr = {AWT'(9), AWT'(9)};
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (isok[b] !== 1'b1) begin
                n_err++; $display("FAIL sb_first_issue b%0d: iss_ok=%b want 1", b, isok[b]);
            end
        end
        cycle();
        // Second issue to 9 with no writeback: WAW stall.
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (rdb[b] !== 2'b11 || isok[b] !== 1'b0) begin
                n_err++;
                $display("FAIL sb_stall b%0d: busy=%b iss_ok=%b want 11 0", b, rdb[b], isok[b]);
            end
        end
        // Writeback to 9 on port 1 in the same cycle as the re-issue.
        set_wr(1, 1'b1, 9, 64'h9999);
        #1;
        n_vec++;
        if (isok[1] !== 1'b1 || isok[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_wb_issue: iss_ok byp=%b nobyp=%b want 1 0", isok[1], isok[0]);
        end
        cycle();
        idle();
        #1;
        n_vec++;
        if (rdb[1] !== 2'b11 || rdb[0] !== 2'b00) begin
            n_err++;
            $display("FAIL sb_set_wins: busy byp=%b nobyp=%b want 11 00", rdb[1], rdb[0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            for (int p = 0; p < NWP; p++)
                set_wr(p, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, NR - 1),
                       {$urandom, $urandom});
            for (int p = 0; p < NRP; p++)
                rd_addr[p*AWT +: AWT] = AWT'($urandom_range(0, 1) ? $urandom_range(0, 3)
                                                                  : $urandom_range(0, NR - 1));
            iss_en = 1'($urandom_range(0, 1));
            iss_addr = AWT'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, NR - 1));
            dbg_addr = AWT'($urandom_range(0, NR - 1));
            #1;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < NRP; p++) begin
                    n_vec++;
                    if (rdd[b][p*XL +: XL] !== exp_rd(b, int'(rd_addr[p*AWT +: AWT])) ||
                        rdb[b][p] !== exp_busy(b, int'(rd_addr[p*AWT +: AWT]))) begin
                        n_err++;
                        $display("FAIL rand_read it%0d b%0d p%0d: data=%h busy=%b want %h %b",
                                 it, b, p, rdd[b][p*XL +: XL], rdb[b][p],
                                 exp_rd(b, int'(rd_addr[p*AWT +: AWT])),
                                 exp_busy(b, int'(rd_addr[p*AWT +: AWT])));
                    end
                end
                n_vec++;
                if (isok[b] !== exp_iss(b) || dbgd[b] !== m_rf[int'(dbg_addr)]) begin
                    n_err++;
                    $display("FAIL rand_iss_dbg it%0d b%0d: iss_ok=%b dbg=%h want %b %h",
                             it, b, isok[b], dbgd[b], exp_iss(b), m_rf[int'(dbg_addr)]);
                end
            end
            cycle();
            for (int b = 0; b < 2; b++) begin
                n_vec++;
                if (resp[b] !== m_resp) begin
                    n_err++;
                    $display("FAIL rand_resp it%0d b%0d: got %b want %b", it, b, resp[b], m_resp);
                end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        set_wr(0, 1'b1, 4, 64'hAAAA_0004);
        set_wr(1, 1'b1, 9, 64'hBBBB_0009);
        cycle();
        idle();
        iss_en = 1'b1; iss_addr = AWT'(4);
        cycle();
        iss_addr = AWT'(9);
        cycle();
        idle();
        rd_addr = {AWT'(9), AWT'(4)};
        dbg_addr = AWT'(4);
        #1;
        n_vec++;
        if (rdb[1] !== 2'b11 || rdd[1] !== {64'hBBBB_0009, 64'hAAAA_0004}) begin
            n_err++;
            $display("FAIL arst_setup: busy=%b data=%h want 11 bbbb0009/aaaa0004", rdb[1], rdd[1]);
        end
        // Write to 12 pending, then reset between edges.
        set_wr(0, 1'b1, 12, 64'hCCCC_000C);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (rdb[b] !== '0 || rdd[b] !== '0 || dbgd[b] !== '0 || resp[b] !== '0) begin
                n_err++;
                $display("FAIL arst_immediate b%0d: busy=%b data=%h dbg=%h resp=%b want all 0",
                         b, rdb[b], rdd[b], dbgd[b], resp[b]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        rd_addr = {AWT'(4), AWT'(12)};
        dbg_addr = AWT'(12);
        #1;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (resp[b] !== '0 || rdd[b] !== '0 || dbgd[b] !== '0) begin
                n_err++;
                $display("FAIL arst_discard b%0d: resp=%b data=%h dbg=%h want all 0",
                         b, resp[b], rdd[b], dbgd[b]);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_bypass();
        test_x0();
        test_conflict();
        test_scoreboard();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
